// File: rtl/line_buffer_5row_ctrl_if.sv
// Bundles the pixel input, the four-RAM A/B port signals and the column output.
// master = the controller side, slave = the environment side (source, RAM bank, sink).
// All signals are plain wires; no flow control beyond the valid strobes.
interface line_buffer_5row_ctrl_if #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 12
);
  logic                    i_sof;
  logic                    i_valid;
  logic [P_DATA_WIDTH-1:0] i_pixel;

  logic [P_ADDR_WIDTH-1:0] addra1, addra2, addra3, addra4;
  logic                    wea1, wea2, wea3, wea4;
  logic [P_DATA_WIDTH-1:0] dina1, dina2, dina3, dina4;
  logic [P_ADDR_WIDTH-1:0] addrb1, addrb2, addrb3, addrb4;
  logic                    enb1, enb2, enb3, enb4;
  logic [P_DATA_WIDTH-1:0] doutb1, doutb2, doutb3, doutb4;

  logic                    o_valid;
  logic [P_DATA_WIDTH-1:0] o_col0, o_col1, o_col2, o_col3, o_col4;
  logic [P_ADDR_WIDTH-1:0] o_col_idx;
  logic                    o_eol;

  modport master (
    input  i_sof, i_valid, i_pixel, doutb1, doutb2, doutb3, doutb4,
    output addra1, addra2, addra3, addra4, wea1, wea2, wea3, wea4,
           dina1, dina2, dina3, dina4, addrb1, addrb2, addrb3, addrb4,
           enb1, enb2, enb3, enb4,
           o_valid, o_col0, o_col1, o_col2, o_col3, o_col4, o_col_idx, o_eol
  );

  modport slave (
    output i_sof, i_valid, i_pixel, doutb1, doutb2, doutb3, doutb4,
    input  addra1, addra2, addra3, addra4, wea1, wea2, wea3, wea4,
           dina1, dina2, dina3, dina4, addrb1, addrb2, addrb3, addrb4,
           enb1, enb2, enb3, enb4,
           o_valid, o_col0, o_col1, o_col2, o_col3, o_col4, o_col_idx, o_eol
  );
endinterface

// File: rtl/line_buffer_5row_ctrl.sv
// Drives a 4-row line-buffer RAM bank and emits a 5-pixel vertical column per input pixel.
// Latency: read enable same cycle as pixel, deferred write +1, column output registered +2.
// No backpressure: 1 pixel/cycle; bubbles (i_valid=0) hold all state.
module line_buffer_5row_ctrl #(
  parameter int P_ROW_WIDTH  = 256,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 12
) (
  input  logic i_clk,
  input  logic i_rst,
  line_buffer_5row_ctrl_if.master bus
);
  localparam logic [P_ADDR_WIDTH-1:0] LAST_COL = P_ADDR_WIDTH'(P_ROW_WIDTH - 1);

  logic [P_ADDR_WIDTH-1:0] col_cnt;
  logic [1:0]              wr_sel;
  logic [2:0]              rows_filled;

  logic [P_ADDR_WIDTH-1:0] base_col, nxt_col;
  logic [1:0]              base_sel, nxt_sel;
  logic [2:0]              base_rf, nxt_rf;
  logic                    row_end;

  // Read/write pipeline stage: pixel waiting for its deferred write
  logic                    s1_vld, s1_full, s1_eol;
  logic [P_ADDR_WIDTH-1:0] s1_col;
  logic [1:0]              s1_sel;
  logic [P_DATA_WIDTH-1:0] s1_pix;

  logic [P_DATA_WIDTH-1:0] dout [4];
  logic [1:0]              sel1, sel2, sel3;

  assign dout[0] = bus.doutb1;
  assign dout[1] = bus.doutb2;
  assign dout[2] = bus.doutb3;
  assign dout[3] = bus.doutb4;

  // Effective counters for this pixel (sof restarts the frame) and their successors
  always_comb begin
    base_col = col_cnt;
    base_sel = wr_sel;
    base_rf  = rows_filled;
    if (bus.i_sof) begin
      base_col = '0;
      base_sel = '0;
      base_rf  = '0;
    end
    row_end = (base_col == LAST_COL);
    nxt_col = base_col + 1'b1;
    nxt_sel = base_sel;
    nxt_rf  = base_rf;
    if (row_end) begin
      nxt_col = '0;
      nxt_sel = base_sel + 2'd1;
      nxt_rf  = (base_rf == 3'd4) ? 3'd4 : base_rf + 3'd1;
    end
  end

  // Port B: all four rows read at the current column in the pixel's own cycle
  assign bus.enb1   = bus.i_valid & ~i_rst;
  assign bus.enb2   = bus.i_valid & ~i_rst;
  assign bus.enb3   = bus.i_valid & ~i_rst;
  assign bus.enb4   = bus.i_valid & ~i_rst;
  assign bus.addrb1 = base_col;
  assign bus.addrb2 = base_col;
  assign bus.addrb3 = base_col;
  assign bus.addrb4 = base_col;

  // Port A: write one cycle later so the old row is read before it is replaced
  assign bus.wea1   = s1_vld & (s1_sel == 2'd0);
  assign bus.wea2   = s1_vld & (s1_sel == 2'd1);
  assign bus.wea3   = s1_vld & (s1_sel == 2'd2);
  assign bus.wea4   = s1_vld & (s1_sel == 2'd3);
  assign bus.addra1 = s1_col;
  assign bus.addra2 = s1_col;
  assign bus.addra3 = s1_col;
  assign bus.addra4 = s1_col;
  assign bus.dina1  = s1_pix;
  assign bus.dina2  = s1_pix;
  assign bus.dina3  = s1_pix;
  assign bus.dina4  = s1_pix;

  // Column / row-slot / fill counters advance only on accepted pixels
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_cnt     <= '0;
      wr_sel      <= '0;
      rows_filled <= '0;
    end else if (bus.i_valid) begin
      col_cnt     <= nxt_col;
      wr_sel      <= nxt_sel;
      rows_filled <= nxt_rf;
    end
  end

  // Capture the pixel and its context alongside the RAM read
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld  <= 1'b0;
      s1_full <= 1'b0;
      s1_eol  <= 1'b0;
      s1_col  <= '0;
      s1_sel  <= '0;
      s1_pix  <= '0;
    end else begin
      s1_vld <= bus.i_valid;
      if (bus.i_valid) begin
        s1_full <= (base_rf == 3'd4);
        s1_eol  <= row_end;
        s1_col  <= base_col;
        s1_sel  <= base_sel;
        s1_pix  <= bus.i_pixel;
      end
    end
  end

  assign sel1 = s1_sel + 2'd1;
  assign sel2 = s1_sel + 2'd2;
  assign sel3 = s1_sel + 2'd3;

  // Rotate RAM outputs so o_col0 is always the oldest row; gate on a full window
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_valid   <= 1'b0;
      bus.o_eol     <= 1'b0;
      bus.o_col0    <= '0;
      bus.o_col1    <= '0;
      bus.o_col2    <= '0;
      bus.o_col3    <= '0;
      bus.o_col4    <= '0;
      bus.o_col_idx <= '0;
    end else begin
      bus.o_valid <= s1_vld & s1_full;
      bus.o_eol   <= s1_vld & s1_full & s1_eol;
      if (s1_vld && s1_full) begin
        bus.o_col0    <= dout[s1_sel];
        bus.o_col1    <= dout[sel1];
        bus.o_col2    <= dout[sel2];
        bus.o_col3    <= dout[sel3];
        bus.o_col4    <= s1_pix;
        bus.o_col_idx <= s1_col;
      end
    end
  end
endmodule

// File: tb/tb_line_buffer_5row_ctrl.sv
module tb_line_buffer_5row_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_buffer_5row_ctrl_if #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(12)) bus ();

  line_buffer_5row_ctrl #(.P_ROW_WIDTH(8), .P_DATA_WIDTH(8), .P_ADDR_WIDTH(12)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  // RAM bank model: synchronous read, 1-cycle latency
  logic [7:0] mem [4][256];
  logic [7:0] dq  [4];
  assign bus.doutb1 = dq[0];
  assign bus.doutb2 = dq[1];
  assign bus.doutb3 = dq[2];
  assign bus.doutb4 = dq[3];

  always @(posedge clk) begin
    if (bus.enb1) dq[0] <= mem[0][bus.addrb1[7:0]];
    if (bus.enb2) dq[1] <= mem[1][bus.addrb2[7:0]];
    if (bus.enb3) dq[2] <= mem[2][bus.addrb3[7:0]];
    if (bus.enb4) dq[3] <= mem[3][bus.addrb4[7:0]];
    if (bus.wea1) mem[0][bus.addra1[7:0]] <= bus.dina1;
    if (bus.wea2) mem[1][bus.addra2[7:0]] <= bus.dina2;
    if (bus.wea3) mem[2][bus.addra3[7:0]] <= bus.dina3;
    if (bus.wea4) mem[3][bus.addra4[7:0]] <= bus.dina4;
  end

  typedef struct {
    logic [4:0][7:0] cols;
    logic [11:0]     idx;
    logic            eol;
    int              cyc;
  } cap_t;

  cap_t q[$];
  int   cyc_n = 0;
  int   wr_count = 0;
  int   viol = 0;
  logic prev_enb = 1'b0;
  logic [11:0] prev_addrb = '0;
  logic [3:0] wea_v, enb_v;

  assign wea_v = {bus.wea4, bus.wea3, bus.wea2, bus.wea1};
  assign enb_v = {bus.enb4, bus.enb3, bus.enb2, bus.enb1};

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Port monitor and output capture, sampled mid-cycle
  always @(negedge clk) begin
    cap_t e;
    if (|wea_v) wr_count = wr_count + 1;
    if (rst) begin
      prev_enb = 1'b0;
    end else begin
      if (bus.wea1 && bus.enb1 && bus.addra1 == bus.addrb1) viol = viol + 1;
      if (bus.wea2 && bus.enb2 && bus.addra2 == bus.addrb2) viol = viol + 1;
      if (bus.wea3 && bus.enb3 && bus.addra3 == bus.addrb3) viol = viol + 1;
      if (bus.wea4 && bus.enb4 && bus.addra4 == bus.addrb4) viol = viol + 1;
      if ((|wea_v) !== prev_enb) viol = viol + 1;
      if ((|wea_v) && (bus.addra1 !== prev_addrb)) viol = viol + 1;
      if ((wea_v & (wea_v - 4'd1)) != 4'd0) viol = viol + 1;
      if (enb_v != 4'h0 && enb_v != 4'hF) viol = viol + 1;
      prev_enb   = bus.enb1;
      prev_addrb = bus.addrb1;
    end
    if (bus.o_valid) begin
      e.cols = {bus.o_col4, bus.o_col3, bus.o_col2, bus.o_col1, bus.o_col0};
      e.idx  = bus.o_col_idx;
      e.eol  = bus.o_eol;
      e.cyc  = cyc_n;
      q.push_back(e);
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic s, input logic [7:0] p);
    bus.i_valid = v;
    bus.i_sof   = s;
    bus.i_pixel = p;
    @(posedge clk);
    #1;
  endtask

  task automatic row(input int r, input bit sof_first, input bit bub, input logic [7:0] base);
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, sof_first && c == 0, 8'(r * 16 + c) + base);
      if (bub) cyc(1'b0, 1'b0, 8'h00);
    end
  endtask

  function automatic int eol_total();
    int n = 0;
    foreach (q[i]) if (q[i].eol) n++;
    return n;
  endfunction

  initial begin
    int wc0;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_pixel = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_o_eol",   64'(bus.o_eol), 64'd0);
    chk("rst_wea",     64'(wea_v), 64'd0);
    chk("rst_enb",     64'(enb_v), 64'd0);
    chk("rst_col_idx", 64'(bus.o_col_idx), 64'd0);
    chk("rst_addra",   64'(bus.addra1), 64'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);

    // Fill: 5 rows, continuous
    q.delete();
    row(0, 1'b1, 1'b0, 8'h00);
    for (int r = 1; r < 5; r++) row(r, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("fill_count",  64'(q.size()), 64'd8);
    chk("fill_first",  64'(q[0].cols), 64'h40_30_20_10_00);
    chk("fill_col3",   64'(q[3].cols), 64'h43_33_23_13_03);
    chk("fill_idx3",   64'(q[3].idx), 64'd3);
    chk("fill_eol_n",  64'(eol_total()), 64'd1);
    chk("fill_eol7",   64'(q[7].eol), 64'd1);

    // Rotation: rows 5..8
    for (int r = 5; r < 9; r++) row(r, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("rot_count",   64'(q.size()), 64'd40);
    chk("rot_row8c0",  64'(q[32].cols), 64'h80_70_60_50_40);

    // Bubbles: alternate valid/idle
    q.delete();
    row(0, 1'b1, 1'b1, 8'h00);
    for (int r = 1; r < 4; r++) row(r, 1'b0, 1'b1, 8'h00);
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 1'b0, 8'(64 + c));
      if (c == 1) chk("bub_lat_gap", 64'(bus.o_valid), 64'd0);
      cyc(1'b0, 1'b0, 8'h00);
      if (c == 1) begin
        chk("bub_lat_vld", 64'(bus.o_valid), 64'd1);
        chk("bub_lat_pix", 64'(bus.o_col4), 64'h41);
      end
    end
    cyc(1'b0, 1'b0, 8'h00);
    chk("bub_count",   64'(q.size()), 64'd8);
    chk("bub_col3",    64'(q[3].cols), 64'h43_33_23_13_03);
    chk("bub_eol7",    64'(q[7].eol), 64'd1);
    chk("bub_spacing", 64'(q[1].cyc - q[0].cyc), 64'd2);

    // Mid-frame sof at row 5 col 4
    q.delete();
    for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 8'(80 + c));
    row(0, 1'b1, 1'b0, 8'h08);
    for (int r = 1; r < 5; r++) row(r, 1'b0, 1'b0, 8'h08);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("sof_count",   64'(q.size()), 64'd12);
    chk("sof_inflight",64'(q[3].cols[4]), 64'h53);
    chk("sof_first",   64'(q[4].cols), 64'h48_38_28_18_08);
    chk("sof_first_idx", 64'(q[4].idx), 64'd0);
    chk("sof_col3",    64'(q[7].cols), 64'h4b_3b_2b_1b_0b);

    // Async reset mid-row
    for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 8'(88 + c));
    chk("arst_pre_vld", 64'(bus.o_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("arst_wea",     64'(wea_v), 64'd0);
    chk("arst_enb",     64'(enb_v), 64'd0);
    chk("arst_eol",     64'(bus.o_eol), 64'd0);
    bus.i_valid = 1'b0;
    wc0 = wr_count;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    chk("arst_no_write", 64'(wr_count), 64'(wc0));
    chk("arst_post_vld", 64'(bus.o_valid), 64'd0);

    // First pixel after release is row 0 col 0 without sof
    q.delete();
    for (int r = 0; r < 5; r++) row(r, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("rel_count",   64'(q.size()), 64'd8);
    chk("rel_first",   64'(q[0].cols), 64'h40_30_20_10_00);
    chk("rel_idx7",    64'(q[7].idx), 64'd7);

    chk("port_rbw_violations", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
